// File: rtl/spr_pkg.sv
// Shared constants, attribute struct and address-width helper for the
// multi-sprite compositor.
package spr_pkg;

    localparam int COLOR_W = 9;   // 3R3G3B
    localparam int COORD_W = 10;  // screen coordinate width

    localparam logic [COLOR_W-1:0] TRANSP_DEF = '0;

    // Per-sprite attributes as held in the frame-synchronous shadow copy.
    typedef struct packed {
        logic               en;
        logic               flip;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } spr_attr_t;

    // Sprite ROM address width for a w x h sprite.
    function automatic int spr_aw(input int w, input int h);
        return $clog2(w * h);
    endfunction

endpackage

// File: rtl/multi_spr_ctrl_if.sv
// Sprite ROM bus: one address and one data lane per sprite channel.
// The compositor (master) drives addresses; the ROM bank (slave) returns
// data a fixed number of clocks later.
interface multi_spr_ctrl_if #(
    parameter int NUM_SPR = 4,
    parameter int AW      = 10,
    parameter int COLOR_W = 9
);
    logic [NUM_SPR*AW-1:0]      spr_adr;
    logic [NUM_SPR*COLOR_W-1:0] spr_dat;

    modport master (output spr_adr, input spr_dat);
    modport slave  (input spr_adr, output spr_dat);
endinterface

// File: rtl/spr_hit_unit.sv
// Per-channel hit test and local ROM address generation (stage S0).
// Purely combinational; all inputs come from the shadow attributes and
// the current pixel position.
module spr_hit_unit
    import spr_pkg::*;
#(
    parameter int SPR_W = 32,
    parameter int SPR_H = 32,
    localparam int XB = $clog2(SPR_W),
    localparam int YB = $clog2(SPR_H),
    localparam int AW = XB + YB
) (
    input  spr_attr_t          i_attr,
    input  logic [COORD_W-1:0] i_pixel_x,
    input  logic [COORD_W-1:0] i_pixel_y,
    input  logic               i_vga_block,
    output logic               o_hit,
    output logic [AW-1:0]      o_adr
);

    logic [COORD_W:0] w_x_end;
    logic [COORD_W:0] w_y_end;
    logic             w_in_x;
    logic             w_in_y;
    logic [XB-1:0]    w_lx;
    logic [XB-1:0]    w_lx_f;
    logic [YB-1:0]    w_ly;

    // Window ends are one bit wider so a sprite near the right/bottom edge
    // is clipped instead of wrapping back to coordinate 0.
    assign w_x_end = {1'b0, i_attr.x} + (COORD_W+1)'(SPR_W);
    assign w_y_end = {1'b0, i_attr.y} + (COORD_W+1)'(SPR_H);
    assign w_in_x  = (i_pixel_x >= i_attr.x) && ({1'b0, i_pixel_x} < w_x_end);
    assign w_in_y  = (i_pixel_y >= i_attr.y) && ({1'b0, i_pixel_y} < w_y_end);

    assign o_hit = i_attr.en && w_in_x && w_in_y && i_vga_block;

    // Only the low bits of the offsets matter inside the window, so the
    // subtraction is done at sprite-coordinate width. Mirroring a
    // power-of-two column index (SPR_W-1-lx) is a bitwise inversion.
    assign w_lx   = i_pixel_x[XB-1:0] - i_attr.x[XB-1:0];
    assign w_ly   = i_pixel_y[YB-1:0] - i_attr.y[YB-1:0];
    assign w_lx_f = w_lx ^ {XB{i_attr.flip}};

    assign o_adr = o_hit ? {w_ly, w_lx_f} : '0;

endmodule

// File: rtl/multi_spr_ctrl.sv
// Multi-sprite compositor: overlays NUM_SPR sprites, lowest index on top,
// onto the VRAM background stream with frame-synchronous attribute shadows.
// Optional sticky collision flags: define MULTI_SPR_COLLIDE_EN.
//
// Stream protocol: there is no valid/ready pair. vga_block acts as the
// per-pixel valid, travels alongside the pixel, and the pipeline never
// stalls (one pixel per clock, fixed RAM_LAT+2 latency).
module multi_spr_ctrl
    import spr_pkg::*;
#(
    parameter int                 NUM_SPR = 4,
    parameter int                 SPR_W   = 32,
    parameter int                 SPR_H   = 32,
    parameter logic [COLOR_W-1:0] TRANSP  = TRANSP_DEF,
    parameter int                 RAM_LAT = 1
) (
    input  logic                       clk_25mhz,
    input  logic                       RST_N,
    input  logic [COORD_W-1:0]         pixel_x,
    input  logic [COORD_W-1:0]         pixel_y,
    input  logic                       vga_block,
    input  logic                       frame_end,
    input  logic [COLOR_W-1:0]         vram_dat,
    input  logic [NUM_SPR-1:0]         spr_en,
    input  logic [NUM_SPR-1:0]         spr_flip,
    input  logic [NUM_SPR*COORD_W-1:0] spr_x,
    input  logic [NUM_SPR*COORD_W-1:0] spr_y,
    multi_spr_ctrl_if.master           rom,
    output logic [COLOR_W-1:0]         vga_dat,
    output logic [NUM_SPR-1:0]         collide
);

    localparam int AW = spr_aw(SPR_W, SPR_H);

    spr_attr_t                       r_attr [NUM_SPR];
    logic [NUM_SPR-1:0]              w_hit;
    logic [NUM_SPR*AW-1:0]           w_adr;
    logic [NUM_SPR*AW-1:0]           r_adr;
    logic [RAM_LAT:0][NUM_SPR-1:0]   r_hit_d;
    logic [RAM_LAT:0]                r_blk_d;
    logic [NUM_SPR-1:0]              w_opaque;
    logic [COLOR_W-1:0]              w_win_dat;
    logic [COLOR_W-1:0]              r_vga_dat;

    // Shadow attributes: captured only at frame_end so a frame never tears.
    always_ff @(posedge clk_25mhz or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_SPR; i++) r_attr[i] <= '0;
        end else if (frame_end) begin
            for (int i = 0; i < NUM_SPR; i++) begin
                r_attr[i] <= '{en:   spr_en[i],
                               flip: spr_flip[i],
                               x:    spr_x[i*COORD_W +: COORD_W],
                               y:    spr_y[i*COORD_W +: COORD_W]};
            end
        end
    end

    // Stage S0: one hit/address unit per channel.
    for (genvar g = 0; g < NUM_SPR; g++) begin : g_hit
        spr_hit_unit #(
            .SPR_W (SPR_W),
            .SPR_H (SPR_H)
        ) u_hit (
            .i_attr      (r_attr[g]),
            .i_pixel_x   (pixel_x),
            .i_pixel_y   (pixel_y),
            .i_vga_block (vga_block),
            .o_hit       (w_hit[g]),
            .o_adr       (w_adr[g*AW +: AW])
        );
    end

    // Stage S1 plus delay line: register ROM addresses, carry hit/valid
    // forward so they line up with ROM data RAM_LAT clocks later.
    always_ff @(posedge clk_25mhz or negedge RST_N) begin
        if (!RST_N) begin
            r_adr   <= '0;
            r_hit_d <= '0;
            r_blk_d <= '0;
        end else begin
            r_adr      <= w_adr;
            r_hit_d[0] <= w_hit;
            r_blk_d[0] <= vga_block;
            for (int k = 1; k <= RAM_LAT; k++) begin
                r_hit_d[k] <= r_hit_d[k-1];
                r_blk_d[k] <= r_blk_d[k-1];
            end
        end
    end

    assign rom.spr_adr = r_adr;

    // Stage S2: opaque test and fixed priority, lowest channel index wins.
    always_comb begin
        w_opaque  = '0;
        w_win_dat = vram_dat;
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            w_opaque[i] = r_hit_d[RAM_LAT][i] &&
                          (rom.spr_dat[i*COLOR_W +: COLOR_W] != TRANSP);
            if (w_opaque[i]) w_win_dat = rom.spr_dat[i*COLOR_W +: COLOR_W];
        end
    end

    // Output register: blank outside the visible area.
    always_ff @(posedge clk_25mhz or negedge RST_N) begin
        if (!RST_N) begin
            r_vga_dat <= '0;
        end else begin
            r_vga_dat <= r_blk_d[RAM_LAT] ? w_win_dat : '0;
        end
    end

    assign vga_dat = r_vga_dat;

`ifdef MULTI_SPR_COLLIDE_EN
    logic               w_multi;
    logic [NUM_SPR-1:0] r_collide;

    // Two or more opaque channels: clearing the lowest set bit leaves a remainder.
    assign w_multi = |(w_opaque & (w_opaque - NUM_SPR'(1)));

    // Sticky collision flags, cleared at frame_end.
    always_ff @(posedge clk_25mhz or negedge RST_N) begin
        if (!RST_N) begin
            r_collide <= '0;
        end else if (frame_end) begin
            r_collide <= '0;
        end else if (w_multi) begin
            r_collide <= r_collide | w_opaque;
        end
    end

    assign collide = r_collide;
`else
    assign collide = '0;
`endif

endmodule
